// File: rtl/noise_channel_ctrl.sv
// APU noise channel: period timer, envelope and length gating of the noise bit.
// Build with NOISE_MODE_EN defined to add the addr1[7] short-mode tap (rand_i[0]^rand_i[6]).
module noise_channel_ctrl #(
  parameter int PERIOD_SHIFT = 4,
  parameter int LEN_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reg_wr,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       qtr_tick,
  input  logic       half_tick,
  input  logic [7:0] rand_i,
  output logic       lfsr_en,
  output logic [3:0] sample_o,
  output logic       active_o
);

  localparam int TW = 4 + PERIOD_SHIFT;
  localparam logic [TW-1:0]    T_ONE = TW'(1);
  localparam logic [LEN_W-1:0] L_ONE = LEN_W'(1);

  logic             enable;
  logic             halt;
  logic             const_vol;
  logic [3:0]       vol_param;
  logic [3:0]       period_idx;
  logic [TW-1:0]    timer;
  logic             noise_bit;
  logic             env_start;
  logic [3:0]       decay;
  logic [3:0]       env_div;
  logic [LEN_W-1:0] length;

  logic [TW:0]   reload_full;
  logic [TW-1:0] reload;
  logic          sel_bit;
  logic          wr0;
  logic          wr1;
  logic          wr3;
  logic          len_ld;
  logic          len_clr;
  logic [3:0]    volume;

  assign wr0     = reg_wr && (reg_addr == 2'd0);
  assign wr1     = reg_wr && (reg_addr == 2'd1);
  assign wr3     = reg_wr && (reg_addr == 2'd3);
  assign len_ld  = reg_wr && (reg_addr == 2'd2) && enable;
  assign len_clr = wr3 && !reg_wdata[0];

  assign reload_full = ({{(TW-3){1'b0}}, period_idx} + 1'b1) << PERIOD_SHIFT;
  assign reload      = reload_full[TW-1:0] - T_ONE;
  assign volume      = const_vol ? vol_param : decay;
  assign lfsr_en     = enable;

`ifdef NOISE_MODE_EN
  logic mode;
  logic unused_rand;
  assign unused_rand = ^{rand_i[7], rand_i[5:1]};
  assign sel_bit     = rand_i[0] ^ (mode & rand_i[6]);

  // Short-mode select, written through addr1[7]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   mode <= 1'b0;
    else if (wr1) mode <= reg_wdata[7];
  end
`else
  logic unused_rand;
  assign unused_rand = ^rand_i[7:1];
  assign sel_bit     = rand_i[0];
`endif

  // Control registers written over the register port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable     <= 1'b0;
      halt       <= 1'b0;
      const_vol  <= 1'b0;
      vol_param  <= 4'd0;
      period_idx <= 4'd0;
    end else begin
      if (wr0) begin
        halt      <= reg_wdata[5];
        const_vol <= reg_wdata[4];
        vol_param <= reg_wdata[3:0];
      end
      if (wr1) period_idx <= reg_wdata[3:0];
      if (wr3) enable     <= reg_wdata[0];
    end
  end

  // Period timer; resamples the noise bit on each reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      noise_bit <= 1'b0;
    end else if (!enable) begin
      timer <= '0;
    end else if (timer == '0) begin
      timer     <= reload;
      noise_bit <= sel_bit;
    end else begin
      timer <= timer - T_ONE;
    end
  end

  // Volume envelope clocked by the quarter-frame tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_start <= 1'b0;
      decay     <= 4'd0;
      env_div   <= 4'd0;
    end else if (qtr_tick) begin
      if (env_start || len_ld) begin
        env_start <= 1'b0;
        decay     <= 4'd15;
        env_div   <= vol_param;
      end else if (env_div == 4'd0) begin
        env_div <= vol_param;
        if (decay != 4'd0) decay <= decay - 4'd1;
        else if (halt)     decay <= 4'd15;
      end else begin
        env_div <= env_div - 4'd1;
      end
    end else if (len_ld) begin
      env_start <= 1'b1;
    end
  end

  // Length counter: clear beats load beats decrement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                length <= '0;
    else if (len_clr)                          length <= '0;
    else if (len_ld)                           length <= LEN_W'(reg_wdata);
    else if (half_tick && !halt && length != '0) length <= length - L_ONE;
  end

  // Registered mixer sample and activity flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_o <= 4'd0;
      active_o <= 1'b0;
    end else begin
      sample_o <= (length == '0 || noise_bit) ? 4'd0 : volume;
      active_o <= (length != '0);
    end
  end

endmodule

// File: tb/tb_noise_channel_ctrl.sv
// Bench for noise_channel_ctrl: directed scenarios plus random traffic
// checked every cycle against a behavioural channel model.
module tb_noise_channel_ctrl;

  localparam int PS = 4;
  localparam int LW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       reg_wr = 1'b0;
  logic [1:0] reg_addr = 2'd0;
  logic [7:0] reg_wdata = 8'd0;
  logic       qtr_tick = 1'b0;
  logic       half_tick = 1'b0;
  logic [7:0] rand_i = 8'd0;
  logic       lfsr_en;
  logic [3:0] sample_o;
  logic       active_o;

  int checks = 0;
  int failures = 0;

  // behavioural channel state
  int m_en, m_halt, m_cv, m_vol, m_idx, m_mode;
  int m_tmr, m_nb, m_es, m_decay, m_div, m_len;
  int m_sample, m_active;

  noise_channel_ctrl #(.PERIOD_SHIFT(PS), .LEN_W(LW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .reg_wr(reg_wr),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .qtr_tick(qtr_tick),
    .half_tick(half_tick),
    .rand_i(rand_i),
    .lfsr_en(lfsr_en),
    .sample_o(sample_o),
    .active_o(active_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_en = 0; m_halt = 0; m_cv = 0; m_vol = 0; m_idx = 0; m_mode = 0;
    m_tmr = 0; m_nb = 0; m_es = 0; m_decay = 0; m_div = 0; m_len = 0;
    m_sample = 0; m_active = 0;
  endtask

  // One clock of the channel, all decisions taken on pre-edge state
  task automatic m_step();
    int w, a, d, ld, bitv;
    w = int'(reg_wr); a = int'(reg_addr); d = int'(reg_wdata);
    m_sample = (m_len == 0 || m_nb != 0) ? 0 : (m_cv != 0 ? m_vol : m_decay);
    m_active = (m_len != 0) ? 1 : 0;
    bitv = int'(rand_i[0]);
    if (m_mode != 0) bitv = bitv ^ int'(rand_i[6]);
    if (m_en == 0) m_tmr = 0;
    else if (m_tmr == 0) begin
      m_tmr = ((m_idx + 1) * (1 << PS)) - 1;
      m_nb = bitv;
    end else m_tmr = m_tmr - 1;
    ld = (w != 0 && a == 2 && m_en != 0) ? 1 : 0;
    if (qtr_tick) begin
      if (m_es != 0 || ld != 0) begin
        m_es = 0; m_decay = 15; m_div = m_vol;
      end else if (m_div == 0) begin
        m_div = m_vol;
        if (m_decay > 0) m_decay = m_decay - 1;
        else if (m_halt != 0) m_decay = 15;
      end else m_div = m_div - 1;
    end else if (ld != 0) m_es = 1;
    if (w != 0 && a == 3 && (d % 2) == 0) m_len = 0;
    else if (ld != 0) m_len = d % (1 << LW);
    else if (half_tick && m_halt == 0 && m_len > 0) m_len = m_len - 1;
    if (w != 0) begin
      case (a)
        0: begin
          m_halt = (d >> 5) & 1; m_cv = (d >> 4) & 1; m_vol = d & 15;
        end
        1: begin
          m_idx = d & 15;
`ifdef NOISE_MODE_EN
          m_mode = (d >> 7) & 1;
`endif
        end
        3: m_en = d & 1;
        default: ;
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
    check("sample", sample_o, m_sample);
    check("active", active_o, m_active);
    check("lfsr_en", lfsr_en, m_en);
  endtask

  task automatic drive(input logic w, input logic [1:0] a, input logic [7:0] d,
                       input logic q, input logic h, input logic [7:0] r);
    reg_wr = w; reg_addr = a; reg_wdata = d;
    qtr_tick = q; half_tick = h; rand_i = r;
    cyc();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    drive(1'b1, a, d, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #2;
    check("rst_sample", sample_o, 0);
    check("rst_active", active_o, 0);
    check("rst_lfsr", lfsr_en, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por_sample", sample_o, 0);
    check("por_active", active_o, 0);
    check("por_lfsr", lfsr_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // period timer with constant volume 10
    wr(2'd3, 8'h01);
    wr(2'd0, 8'h1A);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'd5);
    idle(64);

    // envelope decay without loop, div 1
    wr(2'd0, 8'h01);
    wr(2'd2, 8'd40);
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 2'd0, 8'd0, 1'b1, 1'b0, 8'h00);
      idle(1);
    end
    // envelope loop
    wr(2'd0, 8'h21);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 2'd0, 8'd0, 1'b1, 1'b0, 8'h00);
      idle(1);
    end
    // load together with qtr_tick restarts the envelope at once
    drive(1'b1, 2'd2, 8'd9, 1'b1, 1'b0, 8'h00);
    idle(20);

    // length runs out after three half ticks
    wr(2'd0, 8'h1A);
    wr(2'd2, 8'd3);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 8'h00);
    idle(1);
    check("len_fall", active_o, 0);
    check("len_smp", sample_o, 0);

    // halt holds the length
    wr(2'd0, 8'h3A);
    wr(2'd2, 8'd3);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 8'h00);
    idle(1);
    check("len_halt", active_o, 1);

    // load beats half_tick
    wr(2'd0, 8'h1A);
    drive(1'b1, 2'd2, 8'd7, 1'b0, 1'b1, 8'h00);
    idle(2);
    check("ld_vs_half", active_o, 1);

    // disabled channel ignores loads
    wr(2'd3, 8'h00);
    wr(2'd2, 8'd9);
    idle(2);
    check("dis_len", active_o, 0);
    check("dis_lfsr", lfsr_en, 0);

    // mode tap: rand_i=0x41 at reload
    wr(2'd3, 8'h01);
    wr(2'd0, 8'h1A);
    wr(2'd1, 8'h80);
    wr(2'd2, 8'd50);
    for (int i = 0; i < 20; i++)
      drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 8'h41);
`ifdef NOISE_MODE_EN
    check("mode_smp", sample_o, 10);
`else
    check("mode_smp", sample_o, 0);
`endif

    // reset in the middle of activity
    mid_reset();
    idle(4);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic       w;
      logic [1:0] a;
      logic [7:0] d;
      if ($urandom_range(0, 999) == 0) mid_reset();
      w = ($urandom_range(0, 7) == 0);
      a = 2'($urandom);
      d = 8'($urandom);
      if (a == 2'd3) d[0] = ($urandom_range(0, 4) != 0);
      if (a == 2'd1) d[3:0] = 4'($urandom_range(0, 2));
      drive(w, a, d, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
            8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noise_channel_ctrl.md
Name: noise_channel_ctrl

Overview:
- Noise channel of the APU: the stage directly downstream of the 8-bit pseudo-random generator.
- Consumes the generator's random byte and drives the generator's enable.
- Gates the noise bit with a programmable period timer, a volume envelope and a length counter.
- Produces a 4-bit sample for the APU mixer.

Parameters:
PERIOD_SHIFT, 4, period timer reload = ((idx+1) << PERIOD_SHIFT) - 1; timer width = 4+PERIOD_SHIFT bits
LEN_W, 8, length counter width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
reg_wr  input  1  register write strobe, one-cycle pulse
reg_addr  input  2  register select
reg_wdata  input  8  register write data
qtr_tick  input  1  envelope clock pulse from frame sequencer
half_tick  input  1  length clock pulse from frame sequencer
rand_i  input  8  random byte from noise generator
lfsr_en  output  1  enable to noise generator (low = generator holds seed)
sample_o  output  4  channel sample to mixer
active_o  output  1  high while length counter nonzero

Behaviour:
- Clock and reset: one clock (clk), all flops on posedge clk. Reset is asynchronous, active-low (rst_n). Reset clears all registers, counters, flags and outputs to 0.
- Register map (writes take effect on the clock edge with reg_wr=1):
  - addr0: [5] halt (length halt / envelope loop), [4] const_vol, [3:0] vol_param.
  - addr1: [3:0] period_idx; [7] mode (see optional feature).
  - addr2: length counter load. Loads LEN_W bits of reg_wdata and sets env_start. Ignored if enable=0.
  - addr3: [0] enable. Writing 0 clears the length counter on the same edge.
- lfsr_en = registered enable bit.
  - The generator free-runs while enabled.
  - It reseeds while disabled.
- Period timer:
  - Down-counter.
  - At 0: reload from period_idx and latch noise_bit <= rand_i[0].
  - Otherwise: decrement.
  - Runs only while enable=1. Held at 0 while disabled.
  - A period_idx write does not disturb the current count; the new value is used at the next reload.
- Envelope, on qtr_tick:
  - If env_start: clear env_start, decay=15, env_div=vol_param.
  - Else if env_div==0: env_div=vol_param; then if decay>0, decay-1; else if halt, decay=15 (else decay stays 0).
  - Else: env_div-1.
  - An addr2 write coinciding with qtr_tick acts as a restart in that cycle: decay=15, env_div=vol_param, env_start left clear.
- Length counter, on half_tick: if length>0 and halt=0, length-1; stops at 0 (no wrap).
- Length priority, same cycle: enable-clear > addr2 load > half_tick decrement.
- Volume = const_vol ? vol_param : decay.
- sample_o is registered: 0 if length==0 or noise_bit==1, else volume. One cycle of latency from internal state to sample_o.
- active_o = (length != 0), registered.
- Reset mid-operation: everything returns to 0 immediately. lfsr_en falls, so the generator reseeds.

Optional Feature:
- Macro: NOISE_MODE_EN.
- Defined: addr1[7] stored as mode. On reload, noise_bit latches rand_i[0]^rand_i[6] when mode=1, and rand_i[0] when mode=0.
- Undefined: addr1[7] ignored, no mode flop, noise_bit always latches rand_i[0].

Test Plan:
- Reset: hold rst_n=0 mid-activity -> sample_o=0, active_o=0, lfsr_en=0. Outputs stay 0 after release until registers are written.
- Period and const volume:
  - Stimulus: addr3=1, addr0=0x1A (const, vol 10), addr1=0, addr2=5.
  - Required: noise_bit resamples every 16 cycles.
  - Required: sample_o is 10 when rand_i[0]=0 and 0 when rand_i[0]=1, one cycle after the latch.
- Envelope decay and loop:
  - Stimulus: addr0=0x01 (env, div 1), addr2 load, then pulse qtr_tick.
  - Required with halt=0: decay 15 -> 14 every 2 ticks, down to 0, and stays at 0.
  - Required with addr0=0x21: after 0, decay wraps to 15.
- Length:
  - Stimulus: load 3 with halt=0, then 3 half_tick pulses.
  - Required: active_o falls after the third pulse and sample_o=0.
  - Required with halt=1: length holds at 3.
- Simultaneous events:
  - addr2 load of 7 together with half_tick -> length=7.
  - addr3=0 together with an addr2 load -> length=0, lfsr_en=0.
  - addr2 write together with qtr_tick -> decay=15 that cycle.
- NOISE_MODE_EN: mode=1 and rand_i=0x41 at reload -> noise_bit=0. Same stimulus with the macro undefined -> noise_bit=1.
